// File: rtl/cone_eval_arbiter.sv
// rtl/cone_eval_arbiter.sv - two-port round-robin sequencer for a multicycle combinational cone
module cone_eval_arbiter #(
    parameter int IN_W   = 11,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [IN_W-1:0]  req0_vec,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IN_W-1:0]  req1_vec,
    output logic             req1_ready,
    output logic [IN_W-1:0]  cone_in,
    input  logic             cone_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_bit,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic       last;
    logic [3:0] settle_cnt;
    logic       idle;

    // Readies are gated by rst_n so nothing is accepted while reset is asserted.
    assign idle       = rst_n && (state == S_IDLE);
    assign req0_ready = idle && req0_valid && (!req1_valid || last);
    assign req1_ready = idle && req1_valid && (!req0_valid || !last);
    assign busy       = rst_n && (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last       <= 1'b1;
            settle_cnt <= '0;
            cone_in    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_bit    <= 1'b0;
            done_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        cone_in    <= req1_ready ? req1_vec : req0_vec;
                        rsp_id     <= req1_ready;
                        last       <= req1_ready;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // cone_in has been stable for SETTLE cycles when the count reaches zero
                    if (settle_cnt == 4'd0) begin
                        rsp_bit   <= cone_out;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
